// File: rtl/reg16.sv
// WIDTH-bit storage register with synchronous clear and clock enable.
// Built as per-bit enable-mux + D-flop slices, each powering up at RESET_VALUE.

module reg16_bit #(
    parameter logic INIT = 1'b0
) (
    input  logic CLK,
    input  logic CLR,
    input  logic En,
    input  logic d,
    output logic q
);
    // Declaration initialiser gives the FPGA INIT / simulation power-up value.
    logic q_r = INIT;

    always_ff @(posedge CLK) begin
        if (CLR)
            q_r <= INIT;
        else if (En)
            q_r <= d;
    end

    assign q = q_r;
endmodule

module reg16 #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             En,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        reg16_bit #(.INIT(RESET_VALUE[b])) u_bit (
            .CLK (CLK),
            .CLR (CLR),
            .En  (En),
            .d   (I[b]),
            .q   (Q[b])
        );
    end
endmodule

// File: tb/tb_reg16.sv
// Self-checking bench for reg16: directed vector table, sync/priority corners,
// and randomized traffic against a behavioural reference model.

module tb_reg16;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        en  = 1'b0;
    logic [15:0] i   = '0;
    logic [15:0] q;

    int errors = 0;
    int checks = 0;

    reg16 #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .CLK (clk),
        .CLR (clr),
        .En  (en),
        .I   (i),
        .Q   (q)
    );

    // 20 ns period, first rising edge at 10 ns
    always #10 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        en;
        logic [15:0] i;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] exp);
        checks++;
        if (q !== exp) begin
            errors++;
            $display("FAIL %s: q=%h expected=%h at %0t", name, q, exp, $time);
        end
    endtask

    task automatic add(input logic c, input logic e, input logic [15:0] d,
                       input logic [15:0] x, input string n);
        vec_t v;
        v.clr = c; v.en = e; v.i = d; v.exp = x; v.name = n;
        vecs.push_back(v);
    endtask

    logic [15:0] model;

    initial begin
        // Clear for 120 ns: edges at 10..110 ns, En/I arbitrary
        add(1, 1, 16'h1234, 16'h0000, "clear0");
        add(1, 0, 16'hFFFF, 16'h0000, "clear1");
        add(1, 1, 16'hA5A5, 16'h0000, "clear2");
        add(1, 1, 16'hFFFF, 16'h0000, "clear3");
        add(1, 0, 16'h0001, 16'h0000, "clear4");
        add(1, 1, 16'h8000, 16'h0000, "clear5");
        add(0, 0, 16'd17,    16'h0000, "hold17");
        add(0, 0, 16'd60001, 16'h0000, "hold60001");
        add(0, 1, 16'd60001, 16'hEA61, "load60001");
        add(0, 1, 16'd51234, 16'hC822, "load51234");
        add(0, 1, 16'd320,   16'h0140, "load320");
        add(0, 0, 16'd51210, 16'h0140, "enoff0");
        add(0, 0, 16'd51210, 16'h0140, "enoff1");
        add(0, 0, 16'hBEEF,  16'h0140, "enoff2");
        add(1, 1, 16'hFFFF,  16'h0000, "clrprio");
        add(0, 1, 16'hFFFF,  16'hFFFF, "rt_ffff");
        add(0, 1, 16'h0000,  16'h0000, "rt_0000");
        add(0, 1, 16'h0001,  16'h0001, "lsb");

        #1 check("powerup", 16'h0000);

        foreach (vecs[k]) begin
            clr = vecs[k].clr; en = vecs[k].en; i = vecs[k].i;
            @(posedge clk); #1;
            check(vecs[k].name, vecs[k].exp);
            @(negedge clk);
        end

        // Sync check: Q=1 here. Short CLR pulse fully between edges is ignored.
        clr = 0; en = 0; i = 16'h7777;
        #3 clr = 1;
        #3 check("clr_mid_noeffect", 16'h0001);
        #2 clr = 0;
        @(posedge clk); #1 check("clr_pulse_missed", 16'h0001);

        // CLR raised mid-cycle takes effect only at the next edge
        @(negedge clk); clr = 1;
        #4 check("clr_async_wait", 16'h0001);
        @(posedge clk); #1 check("clr_at_edge", 16'h0000);

        // Mid-cycle I change with En=1: Q follows only at edges
        @(negedge clk); clr = 0; en = 1; i = 16'h1357;
        @(posedge clk); #1 check("sync_load_a", 16'h1357);
        #4 i = 16'h2468;
        #2 check("sync_mid_i", 16'h1357);
        @(posedge clk); #1 check("sync_load_b", 16'h2468);

        // CLR deasserted mid-cycle: clear still applies at this edge? No -- only
        // the level at the edge matters, so a late drop means a load.
        @(negedge clk); clr = 1; i = 16'h0F0F;
        #5 clr = 0;
        @(posedge clk); #1 check("clr_drop_load", 16'h0F0F);

        // Randomized traffic against a rule-level model
        model = 16'h0F0F;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            clr = ($urandom_range(7) == 0);
            en  = $urandom_range(1);
            i   = 16'($urandom);
            #2 check("rand_between", model);
            @(posedge clk);
            if (clr)     model = 16'h0000;
            else if (en) model = i;
            #1 check("rand_edge", model);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end
endmodule
